pkt_tx_sequencer: RTL



---
 rtl/pkt_tx_sequencer.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pkt_tx_sequencer.sv
// NIC transmit sequencer: Wishbone write-burst capture -> converter -> flit injection.
// Define PKT_TX_CREDIT_EN for credit-based flow control; otherwise valid/ready handshake.
module pkt_tx_sequencer #(
  parameter int BUS_DATA_WIDTH    = 32,
  parameter int BUS_ADDRESS_WIDTH = 32,
  parameter int BUS_SEL_WIDTH     = 4,
  parameter int MAX_BURST_LENGHT  = 4,
  parameter int FLIT_WIDTH        = 32,
  parameter int MAX_PACKET_LENGHT = 5,
  parameter int TX_CREDITS        = 4
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        wb_cyc_i,
  input  logic                                        wb_stb_i,
  input  logic                                        wb_we_i,
  input  logic [BUS_ADDRESS_WIDTH-1:0]                wb_adr_i,
  input  logic [BUS_DATA_WIDTH-1:0]                   wb_dat_i,
  input  logic [BUS_SEL_WIDTH-1:0]                    wb_sel_i,
  input  logic [2:0]                                  wb_cti_i,
  output logic                                        wb_ack_o,
  output logic                                        wb_err_o,
  output logic [MAX_BURST_LENGHT*BUS_DATA_WIDTH-1:0]  msg_data_o,
  output logic [BUS_ADDRESS_WIDTH-1:0]                msg_address_o,
  output logic [MAX_BURST_LENGHT*BUS_SEL_WIDTH-1:0]   msg_sel_o,
  input  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0]     pkt_i,
  output logic [FLIT_WIDTH-1:0]                       flit_o,
  output logic                                        flit_valid_o,
  output logic                                        flit_head_o,
  output logic                                        flit_tail_o,
  input  logic                                        credit_i,
  input  logic                                        flit_ready_i,
  output logic                                        busy_o
);

  localparam int BEAT_W = $clog2(MAX_BURST_LENGHT + 1);
  localparam int IDX_W  = $clog2(MAX_PACKET_LENGHT + 1);
  localparam int MSG_W  = MAX_BURST_LENGHT * BUS_DATA_WIDTH;
  localparam int SELS_W = MAX_BURST_LENGHT * BUS_SEL_WIDTH;

  typedef enum logic [1:0] {IDLE, CAPTURE, CONVERT, SEND} state_t;

  state_t                                  state, next_state;
  logic [BEAT_W-1:0]                       beat_cnt, beat_slot, beat_cnt_nxt;
  logic [IDX_W-1:0]                        flit_idx, idx_nxt, nflits, nflits_calc;
  logic [MAX_PACKET_LENGHT*FLIT_WIDTH-1:0] pkt_buf;
  logic [MSG_W-1:0]                        msg_data;
  logic [SELS_W-1:0]                       msg_sel;
  logic [BUS_ADDRESS_WIDTH-1:0]            msg_address;
  logic                                    accept, rd_attempt, last_beat, xfer, is_tail;

`ifdef PKT_TX_CREDIT_EN
  localparam int CRED_W = $clog2(TX_CREDITS + 1);
  logic [CRED_W-1:0] credit_cnt;
  logic              unused_ready;
  assign unused_ready = flit_ready_i;
`else
  logic unused_credit;
  assign unused_credit = credit_i;
`endif

  assign msg_data_o    = msg_data;
  assign msg_sel_o     = msg_sel;
  assign msg_address_o = msg_address;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  // Beat acceptance is gated by the registered ack, which paces the master to one beat per two cycles
  always_comb begin
    accept       = wb_cyc_i & wb_stb_i & wb_we_i & ~wb_ack_o &
                   ((state == IDLE) | (state == CAPTURE));
    rd_attempt   = wb_cyc_i & wb_stb_i & ~wb_we_i & ~wb_err_o & (state == IDLE);
    beat_slot    = (state == IDLE) ? '0 : beat_cnt;
    beat_cnt_nxt = beat_slot + BEAT_W'(1);
    last_beat    = (wb_cti_i == 3'b111) || (beat_cnt_nxt == BEAT_W'(MAX_BURST_LENGHT));
    nflits_calc  = IDX_W'(beat_cnt) + IDX_W'(1);
    if (nflits_calc > IDX_W'(MAX_PACKET_LENGHT)) nflits_calc = IDX_W'(MAX_PACKET_LENGHT);
    idx_nxt      = flit_idx + IDX_W'(1);
    is_tail      = (flit_idx == nflits - IDX_W'(1));
    busy_o       = (state != IDLE);
`ifdef PKT_TX_CREDIT_EN
    flit_valid_o = (state == SEND) && (credit_cnt != '0);
    xfer         = flit_valid_o;
`else
    flit_valid_o = (state == SEND);
    xfer         = flit_valid_o & flit_ready_i;
`endif
    next_state   = state;
    case (state)
      IDLE:    if (accept) next_state = last_beat ? CONVERT : CAPTURE;
      CAPTURE: begin
        if (!wb_cyc_i)               next_state = IDLE;
        else if (accept && last_beat) next_state = CONVERT;
      end
      CONVERT: next_state = SEND;
      SEND:    if (xfer && is_tail) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack_o    <= 1'b0;
      wb_err_o    <= 1'b0;
      beat_cnt    <= '0;
      msg_data    <= '0;
      msg_sel     <= '0;
      msg_address <= '0;
      pkt_buf     <= '0;
      nflits      <= '0;
      flit_idx    <= '0;
      flit_o      <= '0;
      flit_head_o <= 1'b0;
      flit_tail_o <= 1'b0;
    end else begin
      wb_ack_o <= accept;
      wb_err_o <= rd_attempt;
      // The first beat of a burst wipes stale slots so short messages read zero above the last beat
      if (accept) begin
        if (state == IDLE) begin
          msg_data    <= MSG_W'(wb_dat_i);
          msg_sel     <= SELS_W'(wb_sel_i);
          msg_address <= wb_adr_i;
        end else begin
          msg_data[beat_cnt*BUS_DATA_WIDTH +: BUS_DATA_WIDTH] <= wb_dat_i;
          msg_sel[beat_cnt*BUS_SEL_WIDTH +: BUS_SEL_WIDTH]    <= wb_sel_i;
        end
        beat_cnt <= beat_cnt_nxt;
      end
      if (state == CAPTURE && !wb_cyc_i) begin
        msg_data    <= '0;
        msg_sel     <= '0;
        msg_address <= '0;
        beat_cnt    <= '0;
      end
      if (state == CONVERT) begin
        pkt_buf     <= pkt_i;
        nflits      <= nflits_calc;
        flit_idx    <= '0;
        flit_o      <= pkt_i[FLIT_WIDTH-1:0];
        flit_head_o <= 1'b1;
        flit_tail_o <= (nflits_calc == IDX_W'(1));
      end
      // Flit outputs are preloaded for the next index so they stay registered
      if (xfer) begin
        flit_head_o <= 1'b0;
        if (is_tail) begin
          flit_idx    <= '0;
          flit_o      <= '0;
          flit_tail_o <= 1'b0;
        end else begin
          flit_idx    <= idx_nxt;
          flit_o      <= pkt_buf[idx_nxt*FLIT_WIDTH +: FLIT_WIDTH];
          flit_tail_o <= (idx_nxt == nflits - IDX_W'(1));
        end
      end
    end
  end

`ifdef PKT_TX_CREDIT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      credit_cnt <= CRED_W'(TX_CREDITS);
    end else if (xfer && !credit_i) begin
      credit_cnt <= credit_cnt - CRED_W'(1);
    end else if (!xfer && credit_i && (credit_cnt != CRED_W'(TX_CREDITS))) begin
      credit_cnt <= credit_cnt + CRED_W'(1);
    end
  end
`endif

endmodule
